// File: rtl/alu_issue_queue.sv
// Compacting ALU issue queue with CDB wake-up and oldest-ready select; dispatch-to-offer latency 1 cycle.
// disp_ready drops when full or flushing; an unaccepted offer is simply re-selected next cycle.
module alu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int TAGW  = 4,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            disp_valid,
  output logic            disp_ready,
  input  logic [3:0]      disp_aluc,
  input  logic            disp_s1_rdy,
  input  logic            disp_s2_rdy,
  input  logic [31:0]     disp_s1_val,
  input  logic [31:0]     disp_s2_val,
  input  logic [TAGW-1:0] disp_s1_tag,
  input  logic [TAGW-1:0] disp_s2_tag,
  input  logic [TAGW-1:0] disp_dst_tag,
  input  logic            cdb_valid,
  input  logic [TAGW-1:0] cdb_tag,
  input  logic [31:0]     cdb_data,
  output logic            iss_valid,
  input  logic            iss_ready,
  output logic [3:0]      iss_aluc,
  output logic [31:0]     iss_src1,
  output logic [31:0]     iss_src2,
  output logic [TAGW-1:0] iss_tag,
  output logic [CW-1:0]   count
);

  typedef struct packed {
    logic            rdy;
    logic [TAGW-1:0] tag;
    logic [31:0]     val;
  } opnd_t;

  typedef struct packed {
    logic            vld;
    logic [3:0]      aluc;
    opnd_t           s1;
    opnd_t           s2;
    logic [TAGW-1:0] dst;
  } ent_t;

  function automatic opnd_t wake(input opnd_t o, input logic cv,
                                 input logic [TAGW-1:0] ct, input logic [31:0] cd);
    opnd_t r;
    r = o;
    if (cv && !o.rdy && (o.tag == ct)) begin
      r.rdy = 1'b1;
      r.val = cd;
    end
    return r;
  endfunction

  ent_t          ent_q [DEPTH];
  ent_t          ent_d [DEPTH];
  ent_t          woke  [DEPTH+1];
  ent_t          sel_ent;
  ent_t          new_ent;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] sel_idx, wr_idx;
  logic          sel_vld, iss_fire, disp_fire;

  // Descending scan so the lowest eligible index wins.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    sel_ent = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_q[i].vld && ent_q[i].s1.rdy && ent_q[i].s2.rdy) begin
        sel_vld = 1'b1;
        sel_idx = CW'(i);
        sel_ent = ent_q[i];
      end
    end
  end

  assign iss_valid  = sel_vld & ~flush & ~rst;
  assign iss_aluc   = iss_valid ? sel_ent.aluc   : '0;
  assign iss_src1   = iss_valid ? sel_ent.s1.val : '0;
  assign iss_src2   = iss_valid ? sel_ent.s2.val : '0;
  assign iss_tag    = iss_valid ? sel_ent.dst    : '0;
  assign disp_ready = (count_q < CW'(DEPTH)) & ~flush;
  assign iss_fire   = iss_valid & iss_ready;
  assign disp_fire  = disp_valid & disp_ready;
  assign wr_idx     = count_q - CW'(iss_fire);
  assign count      = count_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woke[i]    = ent_q[i];
      woke[i].s1 = wake(ent_q[i].s1, cdb_valid, cdb_tag, cdb_data);
      woke[i].s2 = wake(ent_q[i].s2, cdb_valid, cdb_tag, cdb_data);
    end
    woke[DEPTH] = '0;

    new_ent.vld    = 1'b1;
    new_ent.aluc   = disp_aluc;
    new_ent.dst    = disp_dst_tag;
    new_ent.s1.rdy = disp_s1_rdy;
    new_ent.s1.tag = disp_s1_tag;
    new_ent.s1.val = disp_s1_val;
    new_ent.s2.rdy = disp_s2_rdy;
    new_ent.s2.tag = disp_s2_tag;
    new_ent.s2.val = disp_s2_val;
    new_ent.s1     = wake(new_ent.s1, cdb_valid, cdb_tag, cdb_data);
    new_ent.s2     = wake(new_ent.s2, cdb_valid, cdb_tag, cdb_data);

    // Entries above the issued slot slide down, carrying this edge's wake-ups.
    for (int i = 0; i < DEPTH; i++) begin
      if (iss_fire && (CW'(i) >= sel_idx)) ent_d[i] = woke[i+1];
      else                                 ent_d[i] = woke[i];
      if (disp_fire && (CW'(i) == wr_idx)) ent_d[i] = new_ent;
    end
    count_d = count_q + CW'(disp_fire) - CW'(iss_fire);

    if (flush) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the issue window.
module tb_alu_issue_queue;
  localparam int D  = 4;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst, flush, disp_valid, disp_ready;
  logic [3:0]    disp_aluc;
  logic          disp_s1_rdy, disp_s2_rdy;
  logic [31:0]   disp_s1_val, disp_s2_val;
  logic [TW-1:0] disp_s1_tag, disp_s2_tag, disp_dst_tag;
  logic          cdb_valid;
  logic [TW-1:0] cdb_tag;
  logic [31:0]   cdb_data;
  logic          iss_valid, iss_ready;
  logic [3:0]    iss_aluc;
  logic [31:0]   iss_src1, iss_src2;
  logic [TW-1:0] iss_tag;
  logic [2:0]    count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_issue_queue #(.DEPTH(D), .TAGW(TW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_aluc(disp_aluc),
    .disp_s1_rdy(disp_s1_rdy), .disp_s2_rdy(disp_s2_rdy),
    .disp_s1_val(disp_s1_val), .disp_s2_val(disp_s2_val),
    .disp_s1_tag(disp_s1_tag), .disp_s2_tag(disp_s2_tag), .disp_dst_tag(disp_dst_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_aluc(iss_aluc),
    .iss_src1(iss_src1), .iss_src2(iss_src2), .iss_tag(iss_tag), .count(count)
  );

  // Reference model: an age-ordered list of waiting instructions.
  typedef struct {
    bit [3:0]  aluc;
    bit        r1;
    bit [3:0]  t1;
    bit [31:0] v1;
    bit        r2;
    bit [3:0]  t2;
    bit [31:0] v2;
    bit [3:0]  dst;
  } m_t;
  m_t mq[$];

  function automatic int m_sel();
    foreach (mq[i]) if (mq[i].r1 && mq[i].r2) return i;
    return -1;
  endfunction

  task automatic m_edge();
    int s;
    bit df;
    m_t n;
    if (rst || flush) begin
      mq.delete();
      return;
    end
    s  = m_sel();
    df = disp_valid && (mq.size() < D);
    if (s >= 0 && iss_ready) mq.delete(s);
    foreach (mq[i]) begin
      if (cdb_valid && !mq[i].r1 && mq[i].t1 == cdb_tag) begin mq[i].r1 = 1; mq[i].v1 = cdb_data; end
      if (cdb_valid && !mq[i].r2 && mq[i].t2 == cdb_tag) begin mq[i].r2 = 1; mq[i].v2 = cdb_data; end
    end
    if (df) begin
      n.aluc = disp_aluc; n.dst = disp_dst_tag;
      n.r1 = disp_s1_rdy; n.t1 = disp_s1_tag; n.v1 = disp_s1_val;
      n.r2 = disp_s2_rdy; n.t2 = disp_s2_tag; n.v2 = disp_s2_val;
      if (cdb_valid && !n.r1 && n.t1 == cdb_tag) begin n.r1 = 1; n.v1 = cdb_data; end
      if (cdb_valid && !n.r2 && n.t2 == cdb_tag) begin n.r2 = 1; n.v2 = cdb_data; end
      mq.push_back(n);
    end
  endtask

  task automatic cyc();
    m_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; flush = 0; disp_valid = 0; disp_aluc = 0;
    disp_s1_rdy = 0; disp_s2_rdy = 0; disp_s1_val = 0; disp_s2_val = 0;
    disp_s1_tag = 0; disp_s2_tag = 0; disp_dst_tag = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_data = 0; iss_ready = 0;
  endtask

  task automatic disp(input bit [3:0] a, input bit r1, input bit [31:0] v1, input bit [3:0] t1,
                      input bit r2, input bit [31:0] v2, input bit [3:0] t2, input bit [3:0] dst);
    disp_valid = 1; disp_aluc = a; disp_dst_tag = dst;
    disp_s1_rdy = r1; disp_s1_val = v1; disp_s1_tag = t1;
    disp_s2_rdy = r2; disp_s2_val = v2; disp_s2_tag = t2;
  endtask

  task automatic clear();
    idle(); flush = 1; #1; cyc(); idle(); #1;
  endtask

  task automatic test_reset();
    idle(); rst = 1; #1; cyc(); cyc(); rst = 0; #1;
    tests++; if (iss_valid !== 1'b0) begin fails++; $display("FAIL reset_iss_valid got %0b want 0", iss_valid); end
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d want 0", count); end
    tests++; if (disp_ready !== 1'b1) begin fails++; $display("FAIL reset_disp_ready got %0b want 1", disp_ready); end
    tests++; if ({iss_aluc, iss_src1, iss_src2, iss_tag} !== '0) begin fails++;
      $display("FAIL reset_iss_data got %h want 0", {iss_aluc, iss_src1, iss_src2, iss_tag}); end
  endtask

  task automatic test_basic();
    idle(); disp(4'h0, 1, 32'd5, 0, 1, 32'd7, 0, 4'd3); iss_ready = 1; #1;
    tests++; if (disp_ready !== 1'b1) begin fails++; $display("FAIL basic_disp_ready got %0b want 1", disp_ready); end
    cyc(); idle(); iss_ready = 1; #1;
    tests++; if (iss_valid !== 1'b1) begin fails++; $display("FAIL basic_iss_valid got %0b want 1", iss_valid); end
    tests++; if (iss_src1 !== 32'd5 || iss_src2 !== 32'd7) begin fails++;
      $display("FAIL basic_srcs got %0d,%0d want 5,7", iss_src1, iss_src2); end
    tests++; if (iss_tag !== 4'd3 || iss_aluc !== 4'h0) begin fails++;
      $display("FAIL basic_tag got %0d/%0h want 3/0", iss_tag, iss_aluc); end
    cyc(); idle(); #1;
    tests++; if (count !== 3'd0 || iss_valid !== 1'b0) begin fails++;
      $display("FAIL basic_drain got count=%0d vld=%0b want 0,0", count, iss_valid); end
  endtask

  task automatic test_wake_priority();
    idle(); disp(4'h1, 0, 0, 4'd2, 1, 32'd9, 0, 4'd4); #1; cyc();
    idle(); disp(4'h2, 1, 32'd1, 0, 1, 32'd2, 0, 4'd5); #1; cyc();
    idle(); #1;
    tests++; if (iss_valid !== 1'b1 || iss_tag !== 4'd5) begin fails++;
      $display("FAIL prio_younger got vld=%0b tag=%0d want 1,5", iss_valid, iss_tag); end
    cdb_valid = 1; cdb_tag = 4'd2; cdb_data = 32'h10; #1;
    tests++; if (iss_tag !== 4'd5) begin fails++; $display("FAIL prio_wake_not_early got tag=%0d want 5", iss_tag); end
    cyc(); idle(); #1;
    tests++; if (iss_valid !== 1'b1 || iss_tag !== 4'd4 || iss_src1 !== 32'h10 || iss_src2 !== 32'd9) begin fails++;
      $display("FAIL prio_older got tag=%0d src1=%h src2=%0d want 4,10,9", iss_tag, iss_src1, iss_src2); end
    clear();
  endtask

  task automatic test_dispatch_bypass();
    idle(); disp(4'h3, 1, 32'h11, 0, 0, 0, 4'd6, 4'd7);
    cdb_valid = 1; cdb_tag = 4'd6; cdb_data = 32'hDEAD; #1; cyc();
    idle(); #1;
    tests++; if (iss_valid !== 1'b1 || iss_src2 !== 32'hDEAD || iss_src1 !== 32'h11 || iss_aluc !== 4'h3) begin fails++;
      $display("FAIL bypass got vld=%0b src1=%h src2=%h aluc=%h want 1,11,dead,3", iss_valid, iss_src1, iss_src2, iss_aluc); end
    iss_ready = 1; #1; cyc(); idle(); #1;
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL bypass_drain got %0d want 0", count); end
  endtask

  task automatic test_full();
    for (int i = 0; i < D; i++) begin
      idle(); disp(4'h4, 0, 0, 4'(8 + i), 1, i, 0, 4'(i)); #1; cyc();
    end
    idle(); #1;
    tests++; if (count !== 3'd4 || disp_ready !== 1'b0 || iss_valid !== 1'b0) begin fails++;
      $display("FAIL full_state got count=%0d rdy=%0b vld=%0b want 4,0,0", count, disp_ready, iss_valid); end
    disp(4'h5, 1, 1, 0, 1, 1, 0, 4'd15); #1; cyc(); idle(); #1;
    tests++; if (count !== 3'd4) begin fails++; $display("FAIL full_ignore got %0d want 4", count); end
    cdb_valid = 1; cdb_tag = 4'd9; cdb_data = 32'h55; #1; cyc();
    idle(); iss_ready = 1; #1;
    tests++; if (iss_valid !== 1'b1 || iss_tag !== 4'd1 || iss_src1 !== 32'h55 || iss_src2 !== 32'd1) begin fails++;
      $display("FAIL full_wake got vld=%0b tag=%0d src1=%h want 1,1,55", iss_valid, iss_tag, iss_src1); end
    cyc(); idle(); #1;
    tests++; if (count !== 3'd3 || disp_ready !== 1'b1) begin fails++;
      $display("FAIL full_after_issue got count=%0d rdy=%0b want 3,1", count, disp_ready); end
    clear();
  endtask

  task automatic test_flush();
    for (int i = 1; i <= 3; i++) begin
      idle(); disp(4'h6, 1, i, 0, 1, i, 0, 4'(i)); #1; cyc();
    end
    idle(); disp(4'h7, 1, 1, 0, 1, 1, 0, 4'd9); flush = 1; iss_ready = 1; #1;
    tests++; if (iss_valid !== 1'b0 || disp_ready !== 1'b0) begin fails++;
      $display("FAIL flush_gate got vld=%0b rdy=%0b want 0,0", iss_valid, disp_ready); end
    cyc(); idle(); #1;
    tests++; if (count !== 3'd0 || iss_valid !== 1'b0) begin fails++;
      $display("FAIL flush_clear got count=%0d vld=%0b want 0,0", count, iss_valid); end
  endtask

  task automatic test_back_to_back();
    idle(); disp(4'h8, 1, 32'd10, 0, 1, 32'd11, 0, 4'd1); #1; cyc();
    idle(); disp(4'h9, 1, 32'd20, 0, 1, 32'd21, 0, 4'd2); #1; cyc();
    idle(); disp(4'hA, 1, 32'd30, 0, 1, 32'd31, 0, 4'd3); iss_ready = 1; #1;
    tests++; if (iss_tag !== 4'd1 || count !== 3'd2) begin fails++;
      $display("FAIL b2b_first got tag=%0d count=%0d want 1,2", iss_tag, count); end
    cyc(); idle(); #1;
    tests++; if (count !== 3'd2 || iss_tag !== 4'd2 || iss_src1 !== 32'd20) begin fails++;
      $display("FAIL b2b_order got count=%0d tag=%0d src1=%0d want 2,2,20", count, iss_tag, iss_src1); end
    iss_ready = 1; #1; cyc(); idle(); #1;
    tests++; if (count !== 3'd1 || iss_tag !== 4'd3 || iss_src2 !== 32'd31) begin fails++;
      $display("FAIL b2b_last got count=%0d tag=%0d src2=%0d want 1,3,31", count, iss_tag, iss_src2); end
    clear();
  endtask

  task automatic test_reset_mid();
    idle(); disp(4'hB, 1, 1, 0, 1, 2, 0, 4'd5); #1; cyc();
    idle(); disp(4'hC, 1, 3, 0, 1, 4, 0, 4'd6); #1; cyc();
    idle(); rst = 1; iss_ready = 1; flush = 1; #1;
    tests++; if (iss_valid !== 1'b0) begin fails++; $display("FAIL rstmid_no_issue got %0b want 0", iss_valid); end
    cyc(); idle(); #1;
    tests++; if (count !== 3'd0 || iss_valid !== 1'b0 || disp_ready !== 1'b1) begin fails++;
      $display("FAIL rstmid_state got count=%0d vld=%0b rdy=%0b want 0,0,1", count, iss_valid, disp_ready); end
  endtask

  task automatic test_random();
    int s;
    bit ev;
    for (int n = 0; n < 3000; n++) begin
      idle();
      if ($urandom_range(0, 99) < 60)
        disp(4'($urandom), bit'($urandom), $urandom, 4'($urandom_range(0, 3)),
             bit'($urandom), $urandom, 4'($urandom_range(0, 3)), 4'($urandom));
      cdb_valid = ($urandom_range(0, 99) < 40);
      cdb_tag   = 4'($urandom_range(0, 3));
      cdb_data  = $urandom;
      iss_ready = bit'($urandom);
      flush     = ($urandom_range(0, 99) < 3);
      rst       = ($urandom_range(0, 199) < 1);
      #1;
      s  = m_sel();
      ev = (s >= 0) && !flush && !rst;
      tests++; if (iss_valid !== ev) begin fails++;
        $display("FAIL rand_iss_valid cyc=%0d got %0b want %0b", n, iss_valid, ev); end
      tests++;
      if (ev) begin
        if ({iss_aluc, iss_src1, iss_src2, iss_tag} !== {mq[s].aluc, mq[s].v1, mq[s].v2, mq[s].dst}) begin fails++;
          $display("FAIL rand_iss_data cyc=%0d got %h want %h", n, {iss_aluc, iss_src1, iss_src2, iss_tag},
                   {mq[s].aluc, mq[s].v1, mq[s].v2, mq[s].dst}); end
      end else if ({iss_aluc, iss_src1, iss_src2, iss_tag} !== '0) begin fails++;
        $display("FAIL rand_iss_zero cyc=%0d got %h want 0", n, {iss_aluc, iss_src1, iss_src2, iss_tag}); end
      tests++; if (disp_ready !== ((mq.size() < D) && !flush)) begin fails++;
        $display("FAIL rand_disp_ready cyc=%0d got %0b want %0b", n, disp_ready, (mq.size() < D) && !flush); end
      tests++; if (count !== 3'(mq.size())) begin fails++;
        $display("FAIL rand_count cyc=%0d got %0d want %0d", n, count, mq.size()); end
      cyc();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    test_reset();
    test_basic();
    test_wake_priority();
    test_dispatch_bypass();
    test_full();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
